// File: rtl/main_memory_responder.sv
// Responder side of the cache-to-main-memory req/done handshake with a fixed access latency.
// Optional feature: define MEM_RANGE_CHECK_EN to flag and suppress out-of-range accesses via err.
module main_memory_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic LAT_ONE = (LATENCY == 1);

    state_t            state, state_next;
    logic [7:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic              accept;
    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_bad;
    logic [DEPTH_LOG2-1:0] acc_idx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // With a one-cycle latency the access happens on the acceptance edge itself,
    // so it must use the incoming request rather than the latched copy.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        acc_we     = we_q;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    accept     = 1'b1;
                    state_next = LAT_ONE ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 8'd1) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (req) begin
                    accept     = 1'b1;
                    state_next = LAT_ONE ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (accept && LAT_ONE) begin
            access    = 1'b1;
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
    end

    assign acc_idx = acc_addr[DEPTH_LOG2-1:0];

`ifdef MEM_RANGE_CHECK_EN
    always_comb begin
        acc_bad = ((acc_addr >> DEPTH_LOG2) != '0);
    end
`else
    // Upper address bits deliberately dropped: storage wraps modulo its depth.
    logic unused_hi;
    assign unused_hi = ^(acc_addr >> DEPTH_LOG2);
    always_comb begin
        acc_bad = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= 8'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - 8'd1;
            end
            if (access) begin
                err_q <= acc_bad;
                if (!acc_we) rdata <= acc_bad ? '0 : mem[acc_idx];
            end
        end
    end

    // Storage is never cleared; a reset on the commit edge must still block the write.
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we && !acc_bad) mem[acc_idx] <= acc_wdata;
    end

    assign err = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: one LATENCY=4 and one LATENCY=1 instance
// checked against a word-array reference model.
module tb_main_memory_responder;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, req_a, req_b, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ready_a, done_a, err_a, ready_b, done_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int total = 0;
    int passed = 0;

    logic [31:0] model_a [int];
    logic [31:0] model_b [int];
    logic [31:0] last_a, last_b;

    always #5 clk = ~clk;

    main_memory_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(4)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_a), .done(done_a), .rdata(rdata_a), .err(err_a)
    );

    main_memory_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_b), .done(done_b), .rdata(rdata_b), .err(err_b)
    );

    function automatic bit is_bad(input logic [15:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return (a[15:10] != 6'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request at the current negedge; ends at the negedge of its DONE cycle
    // with req low, so an immediate following call is back-to-back.
    task automatic txn(input bit sel, input bit w, input logic [15:0] a, input logic [31:0] d);
        int          lat;
        int          idx;
        bit          bad;
        logic [31:0] exp_rd;
        logic        rdy, dn, er;
        logic [31:0] rd;
        lat = sel ? 1 : 4;
        idx = int'(a[9:0]);
        bad = is_bad(a);
        rdy = sel ? ready_b : ready_a;
        total++;
        if (rdy !== 1'b1) $display("FAIL ready_before sel=%0d: got %b want 1", sel, rdy);
        else passed++;
        if (w) begin
            exp_rd = sel ? last_b : last_a;
            if (!bad) begin
                if (sel) model_b[idx] = d;
                else     model_a[idx] = d;
            end
        end else begin
            exp_rd = bad ? 32'h0 : (sel ? model_b[idx] : model_a[idx]);
        end
        we = w; addr = a; wdata = d;
        if (sel) req_b = 1'b1;
        else     req_a = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            req_a = 1'b0;
            req_b = 1'b0;
            dn  = sel ? done_b : done_a;
            rdy = sel ? ready_b : ready_a;
            if (k < lat) begin
                total++;
                if (dn !== 1'b0 || rdy !== 1'b0)
                    $display("FAIL busy_cycle k=%0d: got done=%b ready=%b want 0 0", k, dn, rdy);
                else passed++;
            end else begin
                rd = sel ? rdata_b : rdata_a;
                er = sel ? err_b : err_a;
                total++;
                if (dn !== 1'b1 || rdy !== 1'b1)
                    $display("FAIL done_cycle sel=%0d addr=%h: got done=%b ready=%b want 1 1", sel, a, dn, rdy);
                else passed++;
                total++;
                if (rd !== exp_rd)
                    $display("FAIL rdata sel=%0d we=%0d addr=%h: got %h want %h", sel, w, a, rd, exp_rd);
                else passed++;
                total++;
                if (er !== bad) $display("FAIL err sel=%0d addr=%h: got %b want %b", sel, a, er, bad);
                else passed++;
            end
        end
        if (sel) last_b = exp_rd;
        else     last_a = exp_rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (done_a !== 1'b0 || done_b !== 1'b0)
                $display("FAIL idle_done: got %b %b want 0 0", done_a, done_b);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
        we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        total++;
        if ({ready_a, done_a, err_a} !== 3'b100) $display("FAIL reset_a_flags: got %b want 100", {ready_a, done_a, err_a});
        else passed++;
        total++;
        if (rdata_a !== 32'h0) $display("FAIL reset_a_rdata: got %h want 0", rdata_a);
        else passed++;
        total++;
        if ({ready_b, done_b, err_b} !== 3'b100) $display("FAIL reset_b_flags: got %b want 100", {ready_b, done_b, err_b});
        else passed++;
        total++;
        if (rdata_b !== 32'h0) $display("FAIL reset_b_rdata: got %h want 0", rdata_b);
        else passed++;
        last_a = 32'h0;
        last_b = 32'h0;
    endtask

    task automatic test_idle();
        idle(6);
    endtask

    task automatic test_write_read();
        txn(0, 1'b1, 16'h0005, 32'hDEADBEEF);
        idle(1);
        txn(0, 1'b0, 16'h0005, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) txn(0, 1'b1, 16'h0040 + 16'(i), 32'h100 + 32'(i));
        idle(2);
        for (int i = 0; i < 8; i++) txn(0, 1'b0, 16'h0040 + 16'(i), 32'h0);
        idle(1);
    endtask

    task automatic test_latency1();
        txn(1, 1'b1, 16'h0003, 32'h12345678);
        txn(1, 1'b0, 16'h0003, 32'h0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        txn(0, 1'b1, 16'h0010, 32'h11111111);
        idle(1);
        we = 1'b1; addr = 16'h0010; wdata = 32'hA5A5A5A5; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        total++;
        if (ready_a !== 1'b1 || done_a !== 1'b0)
            $display("FAIL reset_mid_flags: got ready=%b done=%b want 1 0", ready_a, done_a);
        else passed++;
        total++;
        if (rdata_a !== 32'h0) $display("FAIL reset_mid_rdata: got %h want 0", rdata_a);
        else passed++;
        last_a = 32'h0;
        idle(4);
        txn(0, 1'b0, 16'h0010, 32'h0);
        idle(1);
    endtask

    task automatic test_range();
        txn(0, 1'b1, 16'h0001, 32'h0BADC0DE);
        idle(1);
        txn(0, 1'b1, 16'h0401, 32'hCAFEF00D);
        idle(1);
        txn(0, 1'b0, 16'h0001, 32'h0);
        idle(1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit          sel;
            bit          w;
            logic [15:0] a;
            logic [31:0] d;
            int          idx;
            sel = n[0];
            w   = 1'($urandom_range(0, 1));
            a   = 16'h0200 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) a[15:10] = 6'($urandom_range(1, 63));
            d   = $urandom;
            idx = int'(a[9:0]);
            if (!w && !(sel ? model_b.exists(idx) : model_a.exists(idx))) w = 1'b1;
            txn(sel, w, a, d);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write_read();
        test_back_to_back();
        test_latency1();
        test_reset_mid();
        test_range();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

- Responder end of the cache-to-main-memory request/done handshake.
- Accepts single-word read and write requests from the cache controller on `req`/`we`/`addr`/`wdata`, models a fixed access latency with a countdown counter, and returns `done` plus `rdata`.
- Sits below the cache controller in the memory system and backs the 8-word block refills and the write-through stores.

## Interface
Parameters:
- `ADDR_W`, 16: word-address width on `addr`.
- `DATA_W`, 32: data word width.
- `DEPTH_LOG2`, 10: storage depth is 2^DEPTH_LOG2 words; must be ≤ ADDR_W.
- `LATENCY`, 4: cycles from request acceptance to `done`; legal range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 1: request strobe; acted on only in a cycle where `ready`=1.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in ADDR_W: word address; sampled with `req`.
- `wdata` in DATA_W: write data; sampled with `req`.
- `ready` out 1: responder can accept a request this cycle.
- `done` out 1: one-cycle completion pulse.
- `rdata` out DATA_W: read data; valid while `done`=1 for a read.
- `err` out 1: range-error flag; only meaningful with `MEM_RANGE_CHECK_EN`, otherwise tied 0.

## Operation
State machine:
- States: IDLE, BUSY, DONE. `ready` = (state==IDLE) || (state==DONE).
- IDLE:
  - `req`=1 latches `we`, `addr` and `wdata` into request registers and loads the counter with LATENCY-1.
  - Next state is BUSY, or DONE directly when LATENCY=1.
  - `req`=0: stay in IDLE.
- BUSY:
  - Decrement the counter each cycle; `req` is ignored.
  - When the counter reaches 1, the next edge enters DONE and performs the access.
- Access (on the edge entering DONE):
  - Write stores the latched `wdata` at `addr[DEPTH_LOG2-1:0]`.
  - Read loads `rdata` from that location.
- DONE:
  - `done`=1 for exactly one cycle.
  - `req`=1 in this cycle is accepted exactly as in IDLE (back-to-back; no bubble). Otherwise go to IDLE.

Data rules:
- `rdata` is updated only on read accesses and holds its value otherwise; writes leave it unchanged.
- Storage contents are not cleared by reset.
- Address bits above DEPTH_LOG2 are ignored unless `MEM_RANGE_CHECK_EN` is defined.

## Timing
- Acceptance edge T is the edge where `req`=1 and `ready`=1.
- `ready`=0 during cycles T+1 .. T+LATENCY-1.
- `done`=1 and `ready`=1 in cycle T+LATENCY.
- Minimum request-to-request spacing is LATENCY cycles.
- A write's data is visible to any read accepted in or after that write's DONE cycle.
- Reset values, applied on the first `rst` edge: state IDLE, `ready`=1, `done`=0, `rdata`=0, `err`=0, counter 0, request registers 0.
- Reset mid-operation: the in-flight request is aborted, no `done` is issued, and a pending write is not committed.
- `rst` has priority over `req` in the same cycle.
- `req` held high across BUSY is not queued; only the DONE/IDLE cycle samples it.

## Configuration
`MEM_RANGE_CHECK_EN`:
- Defined:
  - An access with any `addr` bit at or above DEPTH_LOG2 set still completes with normal latency.
  - `err`=1 together with `done` in that DONE cycle.
  - The write is suppressed; a read returns `rdata`=0.
- Not defined:
  - `err` is constant 0.
  - Upper address bits are ignored, so the address wraps modulo 2^DEPTH_LOG2.

## Test plan
- Reset then idle, LATENCY=4 → `ready`=1, `done`=0, `rdata`=0, `err`=0; no `done` without `req`.
- Write 0xDEADBEEF to 0x0005, then read 0x0005 → each `done` 4 cycles after acceptance; read `rdata`=0xDEADBEEF; `rdata` unchanged by the write.
- 8-word refill: read 0x0040..0x0047, each `req` issued in the previous DONE cycle → 8 `done` pulses exactly 4 cycles apart; data matches preloaded 0x100+i.
- LATENCY=1: write then immediate read of 0x0003 with value 0x12345678 → `done` each cycle after acceptance; read returns 0x12345678.
- `rst` asserted 2 cycles into a write of 0xA5A5A5A5 to 0x0010 (old value 0x11111111) → no `done`; `ready`=1 next cycle; subsequent read returns 0x11111111.
- DEPTH_LOG2=10, write 0xCAFEF00D to 0x0401, then read 0x0001:
  - With macro: write gets `err`=1; read returns the old value.
  - Without macro: write gets `err`=0; read returns 0xCAFEF00D.
